// File: rtl/ppwm_counter_pkg.sv
// Shared types for the PWM time-base counter.
//   mode_e          : counting mode encoding, matches the 2-bit mode_i port.
//   oneshot_state_e : one-shot sequencer states.
package ppwm_counter_pkg;

    typedef enum logic [1:0] {
        UP      = 2'd0,
        UPDOWN  = 2'd1,
        ONESHOT = 2'd2,
        DOWN    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } oneshot_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Tick prescaler: divides the enabled tick stream by prescale_i+1.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   en_i        : enable; low freezes the prescaler
//   tick_i      : one-cycle time-base tick
//   clear_i     : synchronous restart of the prescaler to 0
//   prescale_i  : divide ratio minus one, sampled live
//   step_o      : counter step request, same cycle as the qualifying tick
module tick_prescaler #(
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_i,
    input  logic                      tick_i,
    input  logic                      clear_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic                      step_o
);

    logic [PRESCALE_WIDTH-1:0] presc_r;
    logic                      advance_s;

    assign advance_s = en_i & tick_i;
    // Step is combinational so the counter moves on the edge of the stepping tick.
    assign step_o    = advance_s & (presc_r == prescale_i);

    // Prescaler register: restart on clear, otherwise count enabled ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= {PRESCALE_WIDTH{1'b0}};
        end else if (clear_i) begin
            presc_r <= {PRESCALE_WIDTH{1'b0}};
        end else if (advance_s) begin
            if (step_o) begin
                presc_r <= {PRESCALE_WIDTH{1'b0}};
            end else begin
                presc_r <= presc_r + {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            presc_r <= presc_r;
        end
    end

endmodule

// File: rtl/mode_counter.sv
// Programmable-period PWM time-base counter with four counting modes.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   en_i        : counting enable (low freezes prescaler and counter)
//   tick_i      : one-cycle time-base tick
//   clear_i     : synchronous restart (also latches mode_i)
//   start_i     : one-shot launch (ignored in free-running modes)
//   mode_i      : 0 UP, 1 UPDOWN, 2 ONESHOT, 3 DOWN
//   top_i       : inclusive period end value, sampled live
//   prescale_i  : step every prescale_i+1 enabled ticks
//   count_o     : counter register
//   value_o     : upper HIGH_WIDTH bits of the count (duty-compare value)
//   dir_o       : 1 while counting up
//   wrap_o      : registered one-cycle period-boundary pulse
//   running_o   : counter is advancing in the current mode
module mode_counter
    import ppwm_counter_pkg::*;
#(
    parameter int WIDTH          = 20,
    parameter int HIGH_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_i,
    input  logic                      tick_i,
    input  logic                      clear_i,
    input  logic                      start_i,
    input  logic [1:0]                mode_i,
    input  logic [WIDTH-1:0]          top_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic [WIDTH-1:0]          count_o,
    output logic [HIGH_WIDTH-1:0]     value_o,
    output logic                      dir_o,
    output logic                      wrap_o,
    output logic                      running_o
);

    mode_e          mode_q_r;
    oneshot_state_e state_r;
    logic [WIDTH-1:0] count_r;
    logic             dir_r;
    logic             wrap_r;

    mode_e          mode_in_s;
    logic           step_s;
    logic           restart_s;
    logic           os_start_s;
    logic [WIDTH:0]   count_inc_s;
    logic [WIDTH-1:0] count_dec_s;

    assign mode_in_s   = mode_e'(mode_i);
    // Clear or a mode change both restart the period from scratch.
    assign restart_s   = clear_i | (mode_in_s != mode_q_r);
    // A launch is only accepted while the one-shot is not already running.
    assign os_start_s  = start_i & (mode_q_r == ONESHOT) & (state_r != RUN);
    // One extra bit so the one-shot end test cannot alias at the top of the range.
    assign count_inc_s = {1'b0, count_r} + {{WIDTH{1'b0}}, 1'b1};
    assign count_dec_s = count_r - {{(WIDTH-1){1'b0}}, 1'b1};

    tick_prescaler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en_i),
        .tick_i     (tick_i),
        .clear_i    (restart_s | os_start_s),
        .prescale_i (prescale_i),
        .step_o     (step_s)
    );

    // Counter, direction, wrap pulse, latched mode and one-shot sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q_r <= UP;
            state_r  <= IDLE;
            count_r  <= {WIDTH{1'b0}};
            dir_r    <= 1'b1;
            wrap_r   <= 1'b0;
        end else if (restart_s) begin
            mode_q_r <= mode_in_s;
            state_r  <= IDLE;
            wrap_r   <= 1'b0;
            if (mode_in_s == DOWN) begin
                count_r <= top_i;
                dir_r   <= 1'b0;
            end else begin
                count_r <= {WIDTH{1'b0}};
                dir_r   <= 1'b1;
            end
        end else if (os_start_s) begin
            count_r <= {WIDTH{1'b0}};
            state_r <= RUN;
            wrap_r  <= 1'b0;
        end else if (step_s) begin
            wrap_r <= 1'b0;
            case (mode_q_r)
                UP: begin
                    // count >= top also covers top lowered below the count.
                    if (count_r < top_i) begin
                        count_r <= count_inc_s[WIDTH-1:0];
                    end else begin
                        count_r <= {WIDTH{1'b0}};
                        wrap_r  <= 1'b1;
                    end
                end
                DOWN: begin
                    if ((count_r != {WIDTH{1'b0}}) && (count_r <= top_i)) begin
                        count_r <= count_dec_s;
                    end else begin
                        count_r <= top_i;
                        wrap_r  <= 1'b1;
                    end
                end
                UPDOWN: begin
                    if (top_i == {WIDTH{1'b0}}) begin
                        // Degenerate period: pin at zero and wrap on every step.
                        count_r <= {WIDTH{1'b0}};
                        dir_r   <= 1'b1;
                        wrap_r  <= 1'b1;
                    end else if (dir_r) begin
                        if (count_r < top_i) begin
                            count_r <= count_inc_s[WIDTH-1:0];
                            dir_r   <= (count_inc_s[WIDTH-1:0] != top_i);
                        end else begin
                            count_r <= top_i;
                            dir_r   <= 1'b0;
                        end
                    end else begin
                        count_r <= count_dec_s;
                        if (count_dec_s == {WIDTH{1'b0}}) begin
                            dir_r  <= 1'b1;
                            wrap_r <= 1'b1;
                        end else begin
                            dir_r  <= 1'b0;
                        end
                    end
                end
                ONESHOT: begin
                    if (state_r == RUN) begin
                        if ((top_i == {WIDTH{1'b0}}) || (count_inc_s >= {1'b0, top_i})) begin
                            count_r <= (count_inc_s > {1'b0, top_i}) ? top_i : count_inc_s[WIDTH-1:0];
                            state_r <= DONE;
                            wrap_r  <= 1'b1;
                        end else begin
                            count_r <= count_inc_s[WIDTH-1:0];
                        end
                    end else begin
                        count_r <= count_r;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end else begin
            wrap_r <= 1'b0;
        end
    end

    assign count_o   = count_r;
    assign value_o   = count_r[WIDTH-1 -: HIGH_WIDTH];
    assign dir_o     = dir_r;
    assign wrap_o    = wrap_r;
    assign running_o = en_i & ((mode_q_r != ONESHOT) | (state_r == RUN));

endmodule

// File: tb/tb_mode_counter.sv
// Self-checking bench for mode_counter (WIDTH=8, HIGH_WIDTH=4, PRESCALE_WIDTH=8).
module tb_mode_counter;

    localparam int W  = 8;
    localparam int HW = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en_i, tick_i, clear_i, start_i;
    logic [1:0]    mode_i;
    logic [W-1:0]  top_i;
    logic [PW-1:0] prescale_i;
    logic [W-1:0]  count_o;
    logic [HW-1:0] value_o;
    logic          dir_o, wrap_o, running_o;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    // Reference model state (mode: 0 UP,1 UPDOWN,2 ONESHOT,3 DOWN; state: 0 idle,1 run,2 done)
    int m_count, m_dir, m_wrap, m_mode, m_state, m_presc;

    int up_exp[6]   = '{1, 2, 3, 4, 5, 0};
    int ud_cnt[7]   = '{1, 2, 3, 2, 1, 0, 1};
    int ud_dir[7]   = '{1, 1, 0, 0, 0, 1, 1};
    int ud_wrap[7]  = '{0, 0, 0, 0, 0, 1, 0};

    always #5 clk = ~clk;

    mode_counter #(
        .WIDTH          (W),
        .HIGH_WIDTH     (HW),
        .PRESCALE_WIDTH (PW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en_i),
        .tick_i     (tick_i),
        .clear_i    (clear_i),
        .start_i    (start_i),
        .mode_i     (mode_i),
        .top_i      (top_i),
        .prescale_i (prescale_i),
        .count_o    (count_o),
        .value_o    (value_o),
        .dir_o      (dir_o),
        .wrap_o     (wrap_o),
        .running_o  (running_o)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_dir = 1; m_wrap = 0; m_mode = 0; m_state = 0; m_presc = 0;
    endtask

    // Advances the model by one clock edge from the current inputs.
    task automatic model_update();
        bit adv, stp;
        int nw, t;
        if (!rst_n) begin
            model_reset();
            return;
        end
        t   = int'(top_i);
        adv = en_i && tick_i;
        stp = adv && (m_presc == int'(prescale_i));
        nw  = 0;
        if (adv) m_presc = stp ? 0 : (m_presc + 1) % 256;
        if (clear_i || int'(mode_i) != m_mode) begin
            m_mode  = int'(mode_i);
            m_state = 0;
            m_presc = 0;
            m_count = (m_mode == 3) ? t : 0;
            m_dir   = (m_mode == 3) ? 0 : 1;
        end else if (m_mode == 2 && start_i && m_state != 1) begin
            m_count = 0; m_presc = 0; m_state = 1;
        end else if (stp) begin
            case (m_mode)
                0: if (m_count >= t) begin m_count = 0; nw = 1; end else m_count++;
                3: if (m_count == 0 || m_count > t) begin m_count = t; nw = 1; end else m_count--;
                1: begin
                    if (t == 0) begin
                        m_count = 0; m_dir = 1; nw = 1;
                    end else if (m_dir == 1) begin
                        m_count = (m_count + 1 > t) ? t : m_count + 1;
                        if (m_count == t) m_dir = 0;
                    end else begin
                        m_count--;
                        if (m_count == 0) begin m_dir = 1; nw = 1; end
                    end
                end
                2: if (m_state == 1) begin
                    m_count++;
                    if (m_count >= t) begin m_count = t; m_state = 2; nw = 1; end
                end
                default: ;
            endcase
        end
        m_wrap = nw;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            model_update();
            #1;
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("m_count",   int'(count_o),   m_count);
            chk("m_value",   int'(value_o),   m_count >> 4);
            chk("m_dir",     int'(dir_o),     m_dir);
            chk("m_wrap",    int'(wrap_o),    m_wrap);
            chk("m_running", int'(running_o), (en_i && (m_mode != 2 || m_state == 1)) ? 1 : 0);
        end
    end

    initial begin
        rst_n = 1'b0; en_i = 1'b0; tick_i = 1'b0; clear_i = 1'b0; start_i = 1'b0;
        mode_i = 2'd0; top_i = 8'd5; prescale_i = 8'd0;
        model_reset();
        #12;
        chk("rst_count",   int'(count_o),   0);
        chk("rst_dir",     int'(dir_o),     1);
        chk("rst_wrap",    int'(wrap_o),    0);
        chk("rst_running", int'(running_o), 0);
        cmp_on = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; en_i = 1'b1; tick_i = 1'b1;

        // UP, top=5, every tick a step
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk("up_seq",  int'(count_o), up_exp[i]);
            chk("up_wrap", int'(wrap_o),  (i == 5) ? 1 : 0);
        end
        cyc(1);
        chk("up_wrap_one_cycle", int'(wrap_o), 0);

        // Prescale 2: a step every third enabled tick
        prescale_i = 8'd2; top_i = 8'd3; clear_i = 1'b1;
        cyc(1);
        clear_i = 1'b0;
        chk("ps_clear", int'(count_o), 0);
        cyc(3);
        chk("ps_third_tick", int'(count_o), 1);
        en_i = 1'b0;
        cyc(2);
        chk("ps_en_low", int'(count_o), 1);
        en_i = 1'b1;
        cyc(2);
        chk("ps_no_early", int'(count_o), 1);
        cyc(1);
        chk("ps_step2", int'(count_o), 2);
        tick_i = 1'b0;
        cyc(3);
        chk("ps_no_tick", int'(count_o), 2);
        tick_i = 1'b1;

        // UPDOWN, top=3
        prescale_i = 8'd0; mode_i = 2'd1;
        cyc(1);
        chk("ud_modechg_count", int'(count_o), 0);
        chk("ud_modechg_wrap",  int'(wrap_o),  0);
        for (int i = 0; i < 7; i++) begin
            cyc(1);
            chk("ud_count", int'(count_o), ud_cnt[i]);
            chk("ud_dir",   int'(dir_o),   ud_dir[i]);
            chk("ud_wrap",  int'(wrap_o),  ud_wrap[i]);
        end
        cyc(2);
        chk("ud_pre_rst_dir", int'(dir_o), 0);
        // Asynchronous reset pulse between edges
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_count", int'(count_o), 0);
        chk("arst_dir",   int'(dir_o),   1);
        chk("arst_wrap",  int'(wrap_o),  0);
        cyc(1);
        rst_n = 1'b1;

        // ONESHOT, top=4
        top_i = 8'd4; mode_i = 2'd2;
        cyc(1);
        chk("os_idle_count",   int'(count_o),   0);
        chk("os_idle_running", int'(running_o), 0);
        start_i = 1'b1;
        cyc(1);
        start_i = 1'b0;
        chk("os_start_count",   int'(count_o),   0);
        chk("os_start_running", int'(running_o), 1);
        cyc(2);
        chk("os_count2", int'(count_o), 2);
        start_i = 1'b1;
        cyc(1);
        start_i = 1'b0;
        chk("os_start_in_run", int'(count_o), 3);
        cyc(1);
        chk("os_done_count",   int'(count_o),   4);
        chk("os_done_wrap",    int'(wrap_o),    1);
        chk("os_done_running", int'(running_o), 0);
        cyc(2);
        chk("os_hold", int'(count_o), 4);
        start_i = 1'b1;
        cyc(1);
        start_i = 1'b0;
        chk("os_restart", int'(count_o), 0);
        cyc(1);
        chk("os_restart_step", int'(count_o), 1);

        // UP with top lowered below the count
        mode_i = 2'd0; top_i = 8'd20;
        cyc(1);
        cyc(9);
        chk("up_at9", int'(count_o), 9);
        top_i = 8'd5;
        cyc(1);
        chk("up_lower_top_count", int'(count_o), 0);
        chk("up_lower_top_wrap",  int'(wrap_o),  1);

        // DOWN with top=0 wraps on every step
        mode_i = 2'd3; top_i = 8'd0;
        cyc(1);
        chk("dn_enter_dir", int'(dir_o), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("dn_top0_count", int'(count_o), 0);
            chk("dn_top0_wrap",  int'(wrap_o),  1);
        end
        top_i = 8'h35; clear_i = 1'b1;
        cyc(1);
        clear_i = 1'b0;
        chk("dn_clear_count", int'(count_o), 53);
        chk("dn_clear_value", int'(value_o), 3);
        cyc(1);
        chk("dn_step", int'(count_o), 52);

        // Mode change mid-run
        mode_i = 2'd0;
        cyc(1);
        chk("mc_count", int'(count_o), 0);
        chk("mc_wrap",  int'(wrap_o),  0);
        chk("mc_dir",   int'(dir_o),   1);

        // clear_i together with a step
        prescale_i = 8'd1; top_i = 8'd10;
        cyc(2);
        chk("cs_before", int'(count_o), 1);
        cyc(1);
        clear_i = 1'b1;
        cyc(1);
        clear_i = 1'b0;
        chk("cs_count", int'(count_o), 0);
        chk("cs_wrap",  int'(wrap_o),  0);
        cyc(1);
        chk("cs_presc_restart", int'(count_o), 0);
        cyc(1);
        chk("cs_step_after", int'(count_o), 1);

        @(negedge clk);
        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
